// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port memory with 1-cycle read latency.
// Each transaction walks IDLE -> ISSUE -> WAIT -> ACK; every output is registered.
module mem_arbiter #(
   parameter int AW = 8,
   parameter int DW = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          m0_req_i,
   input  logic          m0_we_i,
   input  logic [AW-1:0] m0_addr_i,
   input  logic [DW-1:0] m0_wdata_i,
   output logic          m0_ack_o,
   output logic [DW-1:0] m0_rdata_o,
   input  logic          m1_req_i,
   input  logic          m1_we_i,
   input  logic [AW-1:0] m1_addr_i,
   input  logic [DW-1:0] m1_wdata_i,
   output logic          m1_ack_o,
   output logic [DW-1:0] m1_rdata_o,
   output logic          mem_en_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i,
   output logic          gnt_o,
   output logic          busy_o
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   state_t        state;
   state_t        state_next;
   logic          lat_we;
   logic          we_next;
   logic          gnt_next;
   logic          win;
   logic [AW-1:0] addr_next;
   logic [DW-1:0] wdata_next;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // mem_addr_o/mem_wdata_o double as the latched request, so they only move on a grant.
   always_comb begin
      state_next = state;
      gnt_next   = gnt_o;
      we_next    = lat_we;
      addr_next  = mem_addr_o;
      wdata_next = mem_wdata_o;
      win        = gnt_o;
      case (state)
         IDLE: begin
            if (m0_req_i || m1_req_i) begin
               if (m0_req_i && m1_req_i) begin
                  win = ~gnt_o;
               end else begin
                  win = m1_req_i;
               end
               gnt_next   = win;
               we_next    = win ? m1_we_i : m0_we_i;
               addr_next  = win ? m1_addr_i : m0_addr_i;
               wdata_next = win ? m1_wdata_i : m0_wdata_i;
               state_next = ISSUE;
            end
         end
         ISSUE:   state_next = WAIT;
         WAIT:    state_next = ACK;
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Strobes are decoded from the next state so they line up with the registered FSM.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         gnt_o       <= 1'b1;
         lat_we      <= 1'b0;
         mem_en_o    <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         busy_o      <= 1'b0;
         m0_ack_o    <= 1'b0;
         m1_ack_o    <= 1'b0;
         m0_rdata_o  <= '0;
         m1_rdata_o  <= '0;
      end else begin
         gnt_o       <= gnt_next;
         lat_we      <= we_next;
         mem_addr_o  <= addr_next;
         mem_wdata_o <= wdata_next;
         mem_en_o    <= (state_next == ISSUE);
         mem_we_o    <= (state_next == ISSUE) && we_next;
         busy_o      <= (state_next != IDLE);
         m0_ack_o    <= (state_next == ACK) && !gnt_next;
         m1_ack_o    <= (state_next == ACK) && gnt_next;
         if ((state == WAIT) && !lat_we) begin
            if (gnt_o) begin
               m1_rdata_o <= mem_rdata_i;
            end else begin
               m0_rdata_o <= mem_rdata_i;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a transaction-level model (grant cycle + fixed offsets).
module tb_mem_arbiter;

   localparam int AW = 8;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m0_we, m1_req, m1_we;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic          m0_ack, m1_ack;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          gnt, busy;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk_i(clk), .rst_i(rst),
      .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
      .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata),
      .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
      .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata), .gnt_o(gnt), .busy_o(busy)
   );

   // Physical memory seen by the DUT; read data is garbage except the cycle after a read strobe.
   logic [DW-1:0] phys_mem [256];
   always @(posedge clk) begin
      if (mem_en && mem_we) phys_mem[mem_addr] = mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= phys_mem[mem_addr];
      else mem_rdata <= $urandom;
   end

   // Reference model: a grant in cycle g gives strobe at g+1, ack at g+3, idle sampling at g+4.
   logic [DW-1:0] ref_mem [256];
   logic          model_valid = 1'b0;
   logic          act = 1'b0;
   int            cyc = 0;
   int            g = 0;
   int            ph;
   logic          t_m, t_we;
   logic [AW-1:0] t_addr;
   logic [DW-1:0] t_wdata, t_rdata;
   logic          e_en, e_we, e_busy, e_ack0, e_ack1, e_gnt;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata, e_rd0, e_rd1;

   always @(posedge clk) begin
      if (rst) begin
         model_valid = 1'b1;
         act = 1'b0;
         e_en = 0; e_we = 0; e_busy = 0; e_ack0 = 0; e_ack1 = 0; e_gnt = 1'b1;
         e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
      end else if (model_valid) begin
         e_en = 0; e_we = 0; e_busy = 0; e_ack0 = 0; e_ack1 = 0;
         if (act) begin
            ph = cyc + 1 - g;
            if (ph <= 3) begin
               e_busy = 1'b1;
               e_en   = (ph == 1);
               e_we   = (ph == 1) && t_we;
               e_ack0 = (ph == 3) && !t_m;
               e_ack1 = (ph == 3) && t_m;
               if (ph == 3 && !t_we) begin
                  if (t_m) e_rd1 = t_rdata;
                  else e_rd0 = t_rdata;
               end
            end else begin
               act = 1'b0;
            end
         end else if (m0_req || m1_req) begin
            t_m     = (m0_req && m1_req) ? ~e_gnt : m1_req;
            t_we    = t_m ? m1_we : m0_we;
            t_addr  = t_m ? m1_addr : m0_addr;
            t_wdata = t_m ? m1_wdata : m0_wdata;
            if (t_we) ref_mem[t_addr] = t_wdata;
            else t_rdata = ref_mem[t_addr];
            act = 1'b1; g = cyc;
            e_gnt = t_m; e_addr = t_addr; e_wdata = t_wdata;
            e_en = 1'b1; e_we = t_we; e_busy = 1'b1;
         end
      end
      cyc++;
   end

   task automatic checkOutput(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
      n_checks++;
      if (act_v !== exp_v) $display("[TB] FAIL %s: got %h, expected %h", name, act_v, exp_v);
      else n_pass++;
   endtask

   always @(negedge clk) begin
      if (model_valid) begin
         checkOutput("mem_en", 32'(mem_en), 32'(e_en));
         checkOutput("mem_we", 32'(mem_we), 32'(e_we));
         checkOutput("mem_addr", 32'(mem_addr), 32'(e_addr));
         checkOutput("mem_wdata", mem_wdata, e_wdata);
         checkOutput("m0_ack", 32'(m0_ack), 32'(e_ack0));
         checkOutput("m1_ack", 32'(m1_ack), 32'(e_ack1));
         checkOutput("m0_rdata", m0_rdata, e_rd0);
         checkOutput("m1_rdata", m1_rdata, e_rd1);
         checkOutput("gnt", 32'(gnt), 32'(e_gnt));
         checkOutput("busy", 32'(busy), 32'(e_busy));
      end
   end

   task automatic applyStimulus(input logic m, input logic req, input logic we,
                                input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      if (m) begin
         m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
      end else begin
         m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
      end
   endtask

   task automatic waitAck(input logic m, input int budget, output int lat);
      logic seen;
      seen = 1'b0;
      lat = 0;
      while (!seen && lat < budget) begin
         @(negedge clk);
         lat++;
         seen = m ? m1_ack : m0_ack;
      end
      if (!seen) begin
         n_checks++;
         $display("[TB] FAIL ack_timeout m%0d: no ack within %0d cycles, expected one", m, budget);
      end
   endtask

   function automatic logic [AW-1:0] pick_addr();
      case ($urandom_range(0, 3))
         0: return 8'h00;
         1: return 8'hFF;
         2: return AW'($urandom_range(0, 15));
         default: return AW'($urandom);
      endcase
   endfunction

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int lat;
      int cnt;
      logic who;
      logic [DW-1:0] v;
      for (int i = 0; i < 256; i++) begin
         v = $urandom;
         phys_mem[i] = v;
         ref_mem[i] = v;
      end
      phys_mem[255] = 32'h12345678;
      ref_mem[255]  = 32'h12345678;
      rst = 1'b1;
      applyStimulus(0, 0, 0, '0, '0);
      applyStimulus(1, 0, 0, '0, '0);
      repeat (3) @(negedge clk);
      checkOutput("reset gnt", 32'(gnt), 32'd1);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset mem_en", 32'(mem_en), 32'd0);
      checkOutput("reset m1_rdata", m1_rdata, 32'd0);
      rst = 1'b0;

      // m0 write
      applyStimulus(0, 1, 1, 8'h04, 32'hDEADBEEF);
      @(negedge clk);
      checkOutput("t1 mem_en", 32'(mem_en), 32'd1);
      checkOutput("t1 mem_we", 32'(mem_we), 32'd1);
      checkOutput("t1 mem_addr", 32'(mem_addr), 32'h04);
      checkOutput("t1 mem_wdata", mem_wdata, 32'hDEADBEEF);
      waitAck(0, 8, lat);
      checkOutput("t1 latency", 32'(lat), 32'd2);
      checkOutput("t1 m1_ack", 32'(m1_ack), 32'd0);
      m0_req = 1'b0;
      @(negedge clk);

      // m1 read of top address
      applyStimulus(1, 1, 0, 8'hFF, 32'h0);
      waitAck(1, 8, lat);
      checkOutput("t2 latency", 32'(lat), 32'd3);
      checkOutput("t2 m1_rdata", m1_rdata, 32'h12345678);
      checkOutput("t2 m0_rdata", m0_rdata, 32'd0);
      m1_req = 1'b0;
      @(negedge clk);

      // Both request right after reset: strict alternation starting with m0
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      applyStimulus(0, 1, 0, 8'h10, 32'h0);
      applyStimulus(1, 1, 1, 8'h11, 32'hA5A5_0011);
      for (int i = 0; i < 8; i++) begin
         cnt = 0;
         do begin
            @(negedge clk);
            cnt++;
         end while (!(m0_ack || m1_ack) && cnt < 8);
         who = m1_ack;
         checkOutput("t3 ack order", 32'(who), 32'(i % 2));
         checkOutput("t3 gnt", 32'(gnt), 32'(i % 2));
      end
      m0_req = 1'b0; m1_req = 1'b0;
      @(negedge clk);

      // Lone m0 granted back-to-back
      applyStimulus(0, 1, 0, 8'h11, 32'h0);
      for (int k = 0; k < 3; k++) begin
         waitAck(0, 8, lat);
         checkOutput("t4 spacing", 32'(lat), (k == 0) ? 32'd3 : 32'd4);
         checkOutput("t4 gnt", 32'(gnt), 32'd0);
      end
      checkOutput("t4 m0_rdata", m0_rdata, 32'hA5A5_0011);
      m0_req = 1'b0;
      @(negedge clk);

      // Request dropped and address changed after the grant
      applyStimulus(0, 1, 1, 8'h20, 32'hCAFEF00D);
      @(negedge clk);
      m0_req = 1'b0;
      m0_addr = 8'h21;
      checkOutput("t5 mem_addr", 32'(mem_addr), 32'h20);
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (m0_ack) cnt++;
      end
      checkOutput("t5 ack count", 32'(cnt), 32'd1);
      applyStimulus(0, 1, 0, 8'h20, 32'h0);
      waitAck(0, 8, lat);
      checkOutput("t5 readback", m0_rdata, 32'hCAFEF00D);
      m0_req = 1'b0;
      @(negedge clk);

      // Reset during the WAIT cycle of a read
      applyStimulus(0, 1, 0, 8'h04, 32'h0);
      @(negedge clk);
      m0_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("t6 busy", 32'(busy), 32'd0);
      checkOutput("t6 mem_en", 32'(mem_en), 32'd0);
      checkOutput("t6 gnt", 32'(gnt), 32'd1);
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (m0_ack) cnt++;
      end
      checkOutput("t6 aborted ack", 32'(cnt), 32'd0);
      applyStimulus(0, 1, 0, 8'h04, 32'h0);
      waitAck(0, 8, lat);
      checkOutput("t6 latency", 32'(lat), 32'd3);
      checkOutput("t6 m0_rdata", m0_rdata, 32'hDEADBEEF);
      m0_req = 1'b0;
      @(negedge clk);

      // Randomized traffic, checked every cycle by the model
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 299) == 0);
         for (int m = 0; m < 2; m++) begin
            logic r, a;
            r = (m == 1) ? m1_req : m0_req;
            a = (m == 1) ? m1_ack : m0_ack;
            if (r && a) begin
               if ($urandom_range(0, 3) != 0) applyStimulus(m[0], 0, 0, pick_addr(), $urandom);
               else applyStimulus(m[0], 1, $urandom_range(0, 1) == 1, pick_addr(), $urandom);
            end else if (!r) begin
               if ($urandom_range(0, 2) == 0)
                  applyStimulus(m[0], 1, $urandom_range(0, 1) == 1, pick_addr(), $urandom);
            end else if ($urandom_range(0, 19) == 0) begin
               applyStimulus(m[0], 0, $urandom_range(0, 1) == 1, pick_addr(), $urandom);
            end
         end
      end
      rst = 1'b0;
      m0_req = 1'b0; m1_req = 1'b0;
      repeat (6) @(negedge clk);
      $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter that shares one single-port 256x32 memory between two masters.
- Each master uses a req/ack handshake.
- The arbiter drives the memory port, which has a fixed 1-cycle read latency, and returns read data to the granted master.
- Sits between datapath users and the shared `mem` array.

Parameters:
- AW, 8, address width (memory depth 2**AW = 256).
- DW, 32, data width.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- m0_req_i  in  1  master 0 request; held high until m0_ack_o.
- m0_we_i  in  1  master 0 write enable (1=write, 0=read).
- m0_addr_i  in  AW  master 0 address.
- m0_wdata_i  in  DW  master 0 write data.
- m0_ack_o  out  1  master 0 completion pulse.
- m0_rdata_o  out  DW  master 0 read data, valid with ack.
- m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_ack_o, m1_rdata_o: same as master 0, for master 1.
- mem_en_o  out  1  memory access strobe.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  AW  memory address.
- mem_wdata_o  out  DW  memory write data.
- mem_rdata_i  in  DW  memory read data; valid the cycle after mem_en_o with mem_we_o=0.
- gnt_o  out  1  index of the current or last granted master.
- busy_o  out  1  high while not in IDLE.

Behaviour:
- All outputs are registered.
- Reset values:
  - state=IDLE.
  - All ack, mem_en_o, mem_we_o, busy_o = 0.
  - mem_addr_o, mem_wdata_o, m*_rdata_o = 0.
  - gnt_o=1, so master 0 wins the first tie.
- FSM states: IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
- IDLE:
  - Sample requests.
  - Only one req high: grant it.
  - Both high: grant the master != gnt_o (strict alternation).
  - Latch we/addr/wdata of the winner and update gnt_o.
  - Go to ISSUE.
  - No req: stay in IDLE.
- ISSUE (one cycle):
  - mem_en_o=1; mem_we_o, mem_addr_o, mem_wdata_o come from the latched request.
- WAIT (one cycle):
  - mem_en_o=0.
  - If the request was a read, capture mem_rdata_i into the granted master's rdata register at the end of the cycle.
- ACK (one cycle):
  - Granted master's ack_o=1 for exactly one cycle.
  - Its rdata_o holds the captured value; it is unchanged for writes and holds until that master's next read completes.
  - The other master's outputs are untouched.
- Latency: req seen in IDLE at cycle T -> mem_en_o at T+1 -> ack_o at T+3. Peak throughput is one transaction per 4 cycles.
- The request is latched in IDLE, so changes to addr/we/wdata after the grant have no effect.
- Req dropped before ack: the transaction still completes and ack still pulses.
- Req still high in the cycle after ack: it is treated as a new request in IDLE.
- Fairness under continuous requests from both masters: grants alternate 0,1,0,1...
- A lone requester may be granted back-to-back.
- busy_o=1 in ISSUE, WAIT and ACK.
- Reset asserted mid-transaction:
  - The next edge forces IDLE and clears all strobes.
  - No ack is issued for the aborted transaction.
  - A write already strobed in ISSUE is not undone.
- Addresses span the full range 0..2**AW-1 with no wrap or modification.

Test Plan:
- Reset, then m0 writes 0xDEADBEEF to addr 0x04 -> mem_en_o=1, mem_we_o=1, mem_addr_o=0x04 at T+1; m0_ack_o pulses at T+3; m1_ack_o stays 0.
- m1 reads addr 0xFF; the memory model returns 0x12345678 -> m1_ack_o at T+3 with m1_rdata_o=0x12345678; m0_rdata_o unchanged.
- Both masters request in the same cycle right after reset -> m0 is granted first (gnt_o=0), m1 next; with both held high, 8 transactions alternate 0,1,0,1,0,1,0,1.
- m0 holds req high alone for 3 transactions -> 3 acks spaced 4 cycles apart, gnt_o=0 throughout.
- m0 drops req one cycle after the grant and changes addr -> memory still sees the original addr, and m0_ack_o still pulses once.
- rst_i asserted in the WAIT cycle of a read -> no ack; next cycle busy_o=0, mem_en_o=0, gnt_o=1; a subsequent m0 request is serviced normally.
